// File: rtl/spiro_measure_ctrl.sv
// Spirometer measurement sequencer: CE prescaler, blow detection, volume/peak accumulation, result hold.
// All outputs registered; a condition sampled at edge N is visible after edge N. No backpressure: iAck/iStart steer the FSM.
module spiro_measure_ctrl #(
    parameter int CE_DIV        = 12_500_000,
    parameter int FLOW_W        = 12,
    parameter int VOL_W         = 24,
    parameter int THRESH        = 100,
    parameter int ARM_TICKS     = 40,
    parameter int MEAS_TICKS    = 24,
    parameter int QUIET_SAMPLES = 8
) (
    input  logic              iClk,
    input  logic              iReset,
    input  logic              iStart,
    input  logic              iAck,
    input  logic              iSampleValid,
    input  logic [FLOW_W-1:0] ivFlow,
    output logic              oCE,
    output logic [1:0]        ovStateMachine,
    output logic [FLOW_W-1:0] ovPeakFlow,
    output logic [VOL_W-1:0]  ovVolume,
    output logic              oValid
);

    localparam int PRE_W    = $clog2(CE_DIV);
    localparam int TICK_MAX = (ARM_TICKS > MEAS_TICKS) ? ARM_TICKS : MEAS_TICKS;
    localparam int TICK_W   = $clog2(TICK_MAX + 1);
    localparam int QUIET_W  = $clog2(QUIET_SAMPLES + 1);

    localparam logic [PRE_W-1:0]   PRE_LAST  = PRE_W'(CE_DIV - 1);
    localparam logic [FLOW_W-1:0]  THRESH_V  = FLOW_W'(THRESH);
    localparam logic [TICK_W-1:0]  ARM_LAST  = TICK_W'(ARM_TICKS - 1);
    localparam logic [TICK_W-1:0]  MEAS_LAST = TICK_W'(MEAS_TICKS - 1);
    localparam logic [QUIET_W-1:0] QUIET_END = QUIET_W'(QUIET_SAMPLES);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MEASURE = 2'd1,
        S_DONE    = 2'd2,
        S_ARMED   = 2'd3
    } state_t;

    state_t              state;
    logic [PRE_W-1:0]    pre_cnt;
    logic [TICK_W-1:0]   tick_cnt;
    logic [QUIET_W-1:0]  quiet_cnt;
    logic                start_q;

    logic                rise;
    logic                below;
    logic                qualify;
    logic [VOL_W:0]      vol_sum;
    logic [VOL_W-1:0]    vol_sat;
    logic [FLOW_W-1:0]   peak_max;
    logic [QUIET_W-1:0]  quiet_next;
    logic                quiet_hit;
    logic                arm_last;
    logic                meas_last;

    // Prescaler free-runs in every state; oCE is the registered terminal-count flag.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            pre_cnt <= '0;
            oCE     <= 1'b0;
        end else begin
            oCE     <= (pre_cnt == PRE_LAST);
            pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PRE_W'(1);
        end
    end

    assign rise       = iStart & ~start_q;
    assign below      = (ivFlow < THRESH_V);
    assign qualify    = iSampleValid & ~below;
    assign vol_sum    = (VOL_W+1)'(ovVolume) + (VOL_W+1)'(ivFlow);
    assign vol_sat    = vol_sum[VOL_W] ? '1 : vol_sum[VOL_W-1:0];
    assign peak_max   = (ivFlow > ovPeakFlow) ? ivFlow : ovPeakFlow;
    assign quiet_next = below ? quiet_cnt + QUIET_W'(1) : '0;
    assign quiet_hit  = iSampleValid & (quiet_next == QUIET_END);
    assign arm_last   = oCE & (tick_cnt == ARM_LAST);
    assign meas_last  = oCE & (tick_cnt == MEAS_LAST);

    assign ovStateMachine = state;

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state      <= S_IDLE;
            start_q    <= 1'b0;
            tick_cnt   <= '0;
            quiet_cnt  <= '0;
            ovVolume   <= '0;
            ovPeakFlow <= '0;
            oValid     <= 1'b0;
        end else begin
            start_q <= iStart;
            case (state)
                S_IDLE: begin
                    if (rise) begin
                        state      <= S_ARMED;
                        tick_cnt   <= '0;
                        quiet_cnt  <= '0;
                        ovVolume   <= '0;
                        ovPeakFlow <= '0;
                    end
                end
                S_ARMED: begin
                    // A qualifying sample beats a simultaneous give-up tick.
                    if (qualify) begin
                        state      <= S_MEASURE;
                        tick_cnt   <= '0;
                        quiet_cnt  <= '0;
                        ovVolume   <= VOL_W'(ivFlow);
                        ovPeakFlow <= ivFlow;
                    end else if (oCE) begin
                        if (arm_last) begin
                            state    <= S_IDLE;
                            tick_cnt <= '0;
                        end else begin
                            tick_cnt <= tick_cnt + TICK_W'(1);
                        end
                    end
                end
                S_MEASURE: begin
                    if (iSampleValid) begin
                        ovVolume   <= vol_sat;
                        ovPeakFlow <= peak_max;
                        quiet_cnt  <= quiet_next;
                    end
                    if (quiet_hit || meas_last) begin
                        state  <= S_DONE;
                        oValid <= 1'b1;
                    end else if (oCE) begin
                        tick_cnt <= tick_cnt + TICK_W'(1);
                    end
                end
                S_DONE: begin
                    if (rise) begin
                        state      <= S_ARMED;
                        oValid     <= 1'b0;
                        tick_cnt   <= '0;
                        quiet_cnt  <= '0;
                        ovVolume   <= '0;
                        ovPeakFlow <= '0;
                    end else if (iAck) begin
                        state  <= S_IDLE;
                        oValid <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    oValid <= 1'b0;
                end
            endcase
        end
    end

endmodule
